// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, FSM state encoding and the per-frame step helper
// for the servo motion scheduler.
//
// Contents:
//   ANG_W, ANG_MAX, ANG_MID, PWM_FRAME  angle width/range and default frame length
//   state_t / StIdle, StUpdate, StSettle  scheduler FSM encoding
//   step_toward()                        one rate-limited move of cur toward tgt
package servo_pkg;

    localparam int unsigned ANG_W     = 9;
    localparam int unsigned ANG_MAX   = 270;
    localparam int unsigned ANG_MID   = 135;
    localparam int unsigned PWM_FRAME = 2_000_000;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StUpdate = 2'd1;
    localparam state_t StSettle = 2'd2;

    // Move cur toward tgt by at most step. Lands exactly on tgt when close
    // enough, so the result never overshoots and stays between cur and tgt.
    function automatic logic [ANG_W-1:0] step_toward(
        input logic [ANG_W-1:0] cur,
        input logic [ANG_W-1:0] tgt,
        input logic [ANG_W-1:0] step
    );
        logic signed [ANG_W:0] diff;
        logic signed [ANG_W:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[ANG_W] ? -diff : diff;
        if (mag <= $signed({1'b0, step})) begin
            return tgt;
        end else if (diff[ANG_W]) begin
            return cur - step;
        end else begin
            return cur + step;
        end
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: free-running PWM frame counter.
//
// Counts 0..FRAME_CYCLES-1 and wraps; frame_tick_o is high for the single
// cycle in which the count equals FRAME_CYCLES-1.
//
// Ports:
//   sclk_i        system clock
//   rst_i         synchronous reset, active-high (count returns to 0)
//   frame_tick_o  1-cycle frame boundary pulse
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = PWM_FRAME
) (
    input  logic sclk_i,
    input  logic rst_i,
    output logic frame_tick_o
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_tick_o = (cnt_q == CntLast);

endmodule

// File: rtl/servo_motion_sched.sv
// servo_motion_sched: rate-limited motion scheduler for NCH hobby servos.
//
// Target angles arrive over a valid/ready handshake (accepted only while
// idle). Once per PWM frame the scheduler walks every channel, one per cycle,
// moving its current angle toward its target by at most STEP_MAX degrees,
// then spends one settle cycle reporting completion.
//
// Configuration macro:
//   SERVO_SOFT_LIMIT_EN  when defined, in-range commands are clamped to
//                        [SOFT_MIN, SOFT_MAX] before being stored as targets.
//
// Ports:
//   sclk_i        system clock
//   rst_i         synchronous reset, active-high
//   cmd_valid_i   command present
//   cmd_ready_o   high only while idle; accept = valid & ready
//   cmd_ch_i      target channel
//   cmd_angle_i   target angle in degrees
//   cmd_err_o     1-cycle pulse after a rejected command
//   angle_out_o   current angles, channel k at [9k+8:9k]
//   frame_tick_o  1-cycle frame boundary pulse
//   busy_o        registered: some channel has not reached its target
//   sig_done_o    pulse in the settle cycle when a pass moved and all settled
module servo_motion_sched
    import servo_pkg::*;
#(
    parameter int unsigned NCH          = 4,
    parameter int unsigned FRAME_CYCLES = PWM_FRAME,
    parameter int unsigned STEP_MAX     = 3,
    parameter int unsigned INIT_ANGLE   = ANG_MID,
    parameter int unsigned SOFT_MIN     = 30,
    parameter int unsigned SOFT_MAX     = 240,
    localparam int unsigned CHW         = $clog2(NCH)
) (
    input  logic                 sclk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [CHW-1:0]       cmd_ch_i,
    input  logic [ANG_W-1:0]     cmd_angle_i,
    output logic                 cmd_err_o,
    output logic [NCH*ANG_W-1:0] angle_out_o,
    output logic                 frame_tick_o,
    output logic                 busy_o,
    output logic                 sig_done_o
);

    localparam logic [ANG_W-1:0] StepAng = ANG_W'(STEP_MAX);
    localparam logic [ANG_W-1:0] InitAng = ANG_W'(INIT_ANGLE);

    logic [ANG_W-1:0] cur_q [NCH];
    logic [ANG_W-1:0] cur_d [NCH];
    logic [ANG_W-1:0] tgt_q [NCH];
    logic [ANG_W-1:0] tgt_d [NCH];
    state_t           state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic             moved_q, moved_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             frame_tick;
    logic             accept;
    logic             cmd_bad;
    logic [ANG_W-1:0] cmd_tgt;

    servo_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_timer (
        .sclk_i       (sclk_i),
        .rst_i        (rst_i),
        .frame_tick_o (frame_tick)
    );

    assign cmd_ready_o = (state_q == StIdle);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign cmd_bad     = (cmd_angle_i > ANG_W'(ANG_MAX)) || (32'(cmd_ch_i) >= NCH);

    always_comb begin
`ifdef SERVO_SOFT_LIMIT_EN
        if (cmd_angle_i < ANG_W'(SOFT_MIN)) begin
            cmd_tgt = ANG_W'(SOFT_MIN);
        end else if (cmd_angle_i > ANG_W'(SOFT_MAX)) begin
            cmd_tgt = ANG_W'(SOFT_MAX);
        end else begin
            cmd_tgt = cmd_angle_i;
        end
`else
        cmd_tgt = cmd_angle_i;
`endif
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        moved_d = moved_q;
        err_d   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cur_d[k] = cur_q[k];
            tgt_d[k] = tgt_q[k];
        end

        // Commands are only accepted in idle, so a pass always sees stable
        // targets; a command taken in the tick cycle lands before the pass.
        if (accept) begin
            if (cmd_bad) begin
                err_d = 1'b1;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (cmd_ch_i == CHW'(k)) begin
                        tgt_d[k] = cmd_tgt;
                    end
                end
            end
        end

        case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    state_d = StUpdate;
                    ch_d    = '0;
                    moved_d = 1'b0;
                end
            end
            StUpdate: begin
                for (int k = 0; k < NCH; k++) begin
                    if (ch_q == CHW'(k)) begin
                        cur_d[k] = step_toward(cur_q[k], tgt_q[k], StepAng);
                        if (cur_q[k] != tgt_q[k]) begin
                            moved_d = 1'b1;
                        end
                    end
                end
                if (ch_q == CHW'(NCH - 1)) begin
                    state_d = StSettle;
                end else begin
                    ch_d = ch_q + CHW'(1);
                end
            end
            StSettle: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Built from next-state values so a new target raises busy the
        // cycle right after it is accepted.
        busy_d = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            busy_d = busy_d | (cur_d[k] != tgt_d[k]);
        end
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ch_q    <= '0;
            moved_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                cur_q[k] <= InitAng;
                tgt_q[k] <= InitAng;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            moved_q <= moved_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            for (int k = 0; k < NCH; k++) begin
                cur_q[k] <= cur_d[k];
                tgt_q[k] <= tgt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            angle_out_o[k*ANG_W +: ANG_W] = cur_q[k];
        end
    end

    assign cmd_err_o    = err_q;
    assign busy_o       = busy_q;
    assign frame_tick_o = frame_tick;
    // busy_q already reflects the last channel's update during settle.
    assign sig_done_o   = (state_q == StSettle) && moved_q && !busy_q;

endmodule

// File: tb/tb_servo_motion_sched.sv
// Testbench for servo_motion_sched: directed stimulus with a small reference
// model; expected results are queued when stimulus is driven and compared
// when the DUT produces them.
module tb_servo_motion_sched;
    import servo_pkg::*;

    localparam int unsigned NCH  = 3;
    localparam int unsigned FC   = 20;
    localparam int          STEP = 3;
    localparam int unsigned AW   = 9;

    logic                sclk = 1'b0;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_ch;
    logic [AW-1:0]       cmd_angle;
    logic                cmd_err;
    logic [NCH*AW-1:0]   angle_out;
    logic                frame_tick;
    logic                busy;
    logic                sig_done;

    servo_motion_sched #(
        .NCH          (NCH),
        .FRAME_CYCLES (FC),
        .STEP_MAX     (STEP),
        .INIT_ANGLE   (135),
        .SOFT_MIN     (30),
        .SOFT_MAX     (240)
    ) dut (
        .sclk_i       (sclk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_ch_i     (cmd_ch),
        .cmd_angle_i  (cmd_angle),
        .cmd_err_o    (cmd_err),
        .angle_out_o  (angle_out),
        .frame_tick_o (frame_tick),
        .busy_o       (busy),
        .sig_done_o   (sig_done)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [NCH*AW-1:0] ang;
        logic              busy;
        logic              done;
    } exp_t;

    exp_t sb_q[$];
    logic err_q[$];

    int errors = 0;
    int checks = 0;
    int m_cur[NCH];
    int m_tgt[NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    function automatic int clamp_model(input int a);
`ifdef SERVO_SOFT_LIMIT_EN
        if (a < 30) return 30;
        if (a > 240) return 240;
        return a;
`else
        return a;
`endif
    endfunction

    function automatic int step_model(input int c, input int t);
        if (t > c + STEP) return c + STEP;
        if (t < c - STEP) return c - STEP;
        return t;
    endfunction

    function automatic logic [NCH*AW-1:0] pack_model();
        logic [NCH*AW-1:0] p;
        for (int k = 0; k < NCH; k++) p[k*AW +: AW] = AW'(m_cur[k]);
        return p;
    endfunction

    function automatic logic busy_model();
        logic b = 1'b0;
        for (int k = 0; k < NCH; k++) b = b | (m_cur[k] != m_tgt[k]);
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_cur[k] = 135;
            m_tgt[k] = 135;
        end
    endtask

    // Push the expected error flag for the command currently on the bus.
    task automatic model_accept();
        logic bad;
        bad = (int'(cmd_angle) > 270) || (int'(cmd_ch) >= NCH);
        if (!bad) m_tgt[cmd_ch] = clamp_model(int'(cmd_angle));
        err_q.push_back(bad);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (frame_tick !== 1'b1 && n < int'(FC) + 5) begin
            tick();
            n++;
        end
        chk("frame_tick_seen", 64'(frame_tick), 64'd1);
    endtask

    task automatic send(input logic [1:0] ch, input int ang);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2 * int'(FC)) begin
            tick();
            n++;
        end
        chk("ready_before_send", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_angle = AW'(ang);
        model_accept();
        tick();
        cmd_valid = 1'b0;
        chk("cmd_err", 64'(cmd_err), 64'(err_q.pop_front()));
        chk("busy_after_cmd", 64'(busy), 64'(busy_model()));
        tick();
        chk("cmd_err_pulse_end", 64'(cmd_err), 64'd0);
    endtask

    // One full frame pass. at_tick: cmd_ch/cmd_angle are presented in the
    // tick cycle. hold: they are presented from the first UPDATE cycle on
    // and must not be taken until the scheduler is idle again.
    task automatic run_pass(input bit at_tick, input bit hold);
        int   n;
        int   old;
        bit   moved;
        exp_t e;
        wait_tick(n);
        if (at_tick) begin
            cmd_valid = 1'b1;
            model_accept();
        end
        moved = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            old      = m_cur[k];
            m_cur[k] = step_model(m_cur[k], m_tgt[k]);
            if (m_cur[k] != old) moved = 1'b1;
        end
        e.ang  = pack_model();
        e.busy = busy_model();
        e.done = moved && !e.busy;
        sb_q.push_back(e);
        tick();
        cmd_valid = hold;
        if (at_tick) chk("cmd_err_tick", 64'(cmd_err), 64'(err_q.pop_front()));
        chk("ready_in_update", 64'(cmd_ready), 64'd0);
        repeat (NCH) begin
            tick();
            chk("ready_low_in_pass", 64'(cmd_ready), 64'd0);
        end
        e = sb_q.pop_front();
        chk("angle_out", 64'(angle_out), 64'(e.ang));
        chk("busy_settle", 64'(busy), 64'(e.busy));
        chk("sig_done", 64'(sig_done), 64'(e.done));
        tick();
        chk("sig_done_pulse_end", 64'(sig_done), 64'd0);
        chk("ready_idle", 64'(cmd_ready), 64'd1);
        if (hold) begin
            model_accept();
            tick();
            cmd_valid = 1'b0;
            chk("cmd_err_held", 64'(cmd_err), 64'(err_q.pop_front()));
            chk("busy_after_held", 64'(busy), 64'(busy_model()));
        end
    endtask

    initial begin
        int n;
        int per;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_angle = '0;
        model_reset();
        repeat (3) tick();

        // Reset state
        chk("rst_angle", 64'(angle_out), 64'(pack_model()));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_err", 64'(cmd_err), 64'd0);
        chk("rst_tick", 64'(frame_tick), 64'd0);
        chk("rst_done", 64'(sig_done), 64'd0);
        rst = 1'b0;

        // Frame tick period and width, then quiet frames
        wait_tick(n);
        tick();
        chk("tick_width", 64'(frame_tick), 64'd0);
        per = 1;
        wait_tick(n);
        per += n;
        chk("tick_period", 64'(per), 64'(FC));
        repeat (3) run_pass(1'b0, 1'b0);

        // Rejected commands leave targets alone
        send(2'd0, 300);
        send(2'd3, 100);

        // Small move: one step then landing exactly
        send(2'd0, 141);
        repeat (2) run_pass(1'b0, 1'b0);

        // Long move down to the range floor, then idle pass
        send(2'd1, 0);
        repeat (46) run_pass(1'b0, 1'b0);

        // Command held through a pass is taken only once idle
        cmd_ch    = 2'd0;
        cmd_angle = AW'(120);
        run_pass(1'b0, 1'b1);
        repeat (7) run_pass(1'b0, 1'b0);

        // Command in the tick cycle is used by that same pass
        cmd_ch    = 2'd0;
        cmd_angle = AW'(123);
        run_pass(1'b1, 1'b0);

        // Upper boundary accepted, then reset mid-pass
        send(2'd2, 270);
        run_pass(1'b0, 1'b0);
        wait_tick(n);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midrst_angle", 64'(angle_out), 64'(pack_model()));
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_done", 64'(sig_done), 64'd0);
        run_pass(1'b0, 1'b0);

`ifdef SERVO_SOFT_LIMIT_EN
        send(2'd0, 10);
        run_pass(1'b0, 1'b0);
`else
        send(2'd0, 10);
        run_pass(1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
